// File: rtl/cmd_cntrl.sv
// Command controller: takes GO/STOP commands, holds the vehicle in transit until the
// barcode reader reports the destination station, and drives go plus a blocked-path buzzer.
module cmd_cntrl #(
    parameter int BUZZ_HALF = 12500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       in_transit,
    output logic       go,
    output logic       buzz,
    output logic       buzz_n,
    output logic       fsm_state
);

    // Handshake: a producer holds its valid flag until it sees a one-cycle clear pulse,
    // and drops it at the following edge. A flag is only looked at while its own clear is
    // low, so a held flag is never consumed twice.

    typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;

    localparam logic [1:0]  OP_STOP = 2'b00;
    localparam logic [1:0]  OP_GO   = 2'b01;
    localparam logic [14:0] HALF_M1 = 15'(BUZZ_HALF - 1);

    state_t      state, next_state;
    logic [5:0]  dest_id, next_dest_id;
    logic        next_clr_cmd, next_clr_id;
    logic        cmd_q, id_q;
    logic [1:0]  opcode;
    logic [14:0] buzz_cnt;
    logic        blocked;

    assign opcode = cmd[7:6];
    assign cmd_q  = cmd_rdy & ~clr_cmd_rdy;
    assign id_q   = ID_vld & ~clr_ID_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dest_id     <= 6'd0;
            clr_cmd_rdy <= 1'b0;
            clr_ID_vld  <= 1'b0;
        end else begin
            state       <= next_state;
            dest_id     <= next_dest_id;
            clr_cmd_rdy <= next_clr_cmd;
            clr_ID_vld  <= next_clr_id;
        end
    end

    always_comb begin
        next_state   = state;
        next_dest_id = dest_id;
        next_clr_cmd = 1'b0;
        next_clr_id  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_q) begin
                    next_clr_cmd = 1'b1;
                    if (opcode == OP_GO) begin
                        next_dest_id = cmd[5:0];
                        next_state   = MOVE;
                    end
                end
                // Station reports while parked are acknowledged and thrown away.
                if (id_q)
                    next_clr_id = 1'b1;
            end
            MOVE: begin
                if (cmd_q) begin
                    next_clr_cmd = 1'b1;
                    if (opcode == OP_STOP)
                        next_state = IDLE;
                    else if (opcode == OP_GO)
                        next_dest_id = cmd[5:0];
                end else if (id_q) begin
                    next_clr_id = 1'b1;
                    // ID[7:6] is always 00 on a valid report.
                    if (ID == {2'b00, dest_id})
                        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign in_transit = (state == MOVE);
    assign fsm_state  = state;
    assign go         = in_transit & OK2Move;
    assign blocked    = in_transit & ~OK2Move;

    always_ff @(posedge clk) begin
        if (!rst_n || !blocked) begin
            buzz_cnt <= 15'd0;
            buzz     <= 1'b0;
        end else if (buzz_cnt == HALF_M1) begin
            buzz_cnt <= 15'd0;
            buzz     <= ~buzz;
        end else begin
            buzz_cnt <= buzz_cnt + 15'd1;
        end
    end

    assign buzz_n = ~buzz;

endmodule

// File: tb/tb_cmd_cntrl.sv
// Directed testbench for cmd_cntrl: one task per scenario, inline checks against
// hand-computed expectations, BUZZ_HALF shrunk to 4.
module tb_cmd_cntrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] id;
    logic       id_vld;
    logic       clr_id_vld;
    logic       ok2move;
    logic       in_transit;
    logic       go;
    logic       buzz;
    logic       buzz_n;
    logic       fsm_state;

    int vectors;
    int miscompares;

    cmd_cntrl #(.BUZZ_HALF(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .ID          (id),
        .ID_vld      (id_vld),
        .clr_ID_vld  (clr_id_vld),
        .OK2Move     (ok2move),
        .in_transit  (in_transit),
        .go          (go),
        .buzz        (buzz),
        .buzz_n      (buzz_n),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [7:0] c, input logic exp_transit);
        cmd     = c;
        cmd_rdy = 1'b1;
        step();
        vectors++;
        if (clr_cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ack cmd=%h clr_cmd_rdy=%b expected 1", c, clr_cmd_rdy);
        end
        vectors++;
        if (in_transit !== exp_transit) begin
            miscompares++;
            $display("FAIL cmd_transit cmd=%h in_transit=%b expected %b", c, in_transit, exp_transit);
        end
        cmd_rdy = 1'b0;
        step();
        vectors++;
        if (clr_cmd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_ack_width cmd=%h clr_cmd_rdy=%b expected 0", c, clr_cmd_rdy);
        end
    endtask

    task automatic do_id(input logic [7:0] s, input logic exp_transit);
        id     = s;
        id_vld = 1'b1;
        step();
        vectors++;
        if (clr_id_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL id_ack id=%h clr_ID_vld=%b expected 1", s, clr_id_vld);
        end
        vectors++;
        if (in_transit !== exp_transit) begin
            miscompares++;
            $display("FAIL id_transit id=%h in_transit=%b expected %b", s, in_transit, exp_transit);
        end
        id_vld = 1'b0;
        step();
        vectors++;
        if (clr_id_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL id_ack_width id=%h clr_ID_vld=%b expected 0", s, clr_id_vld);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        cmd     = 8'h00;
        cmd_rdy = 1'b1;
        ok2move = 1'b1;
        step();
        step();
        vectors++;
        if ({clr_cmd_rdy, clr_id_vld, in_transit, go, buzz, buzz_n, fsm_state} !== 7'b0000010) begin
            miscompares++;
            $display("FAIL reset_outputs got %b expected 0000010",
                     {clr_cmd_rdy, clr_id_vld, in_transit, go, buzz, buzz_n, fsm_state});
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (clr_cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ack clr_cmd_rdy=%b expected 1", clr_cmd_rdy);
        end
        cmd_rdy = 1'b0;
        step();
        vectors++;
        if (clr_cmd_rdy !== 1'b0 || in_transit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_single clr_cmd_rdy=%b in_transit=%b expected 0 0",
                     clr_cmd_rdy, in_transit);
        end
    endtask

    task automatic test_go_match();
        ok2move = 1'b1;
        do_cmd(8'h45, 1'b1);
        vectors++;
        if (go !== 1'b1) begin
            miscompares++;
            $display("FAIL go_in_move go=%b expected 1", go);
        end
        do_id(8'h03, 1'b1);
        do_id(8'h05, 1'b0);
        vectors++;
        if (go !== 1'b0) begin
            miscompares++;
            $display("FAIL go_after_arrive go=%b expected 0", go);
        end
    endtask

    task automatic test_stop();
        do_cmd(8'h4A, 1'b1);
        do_cmd(8'h00, 1'b0);
        do_id(8'h0A, 1'b0);
    endtask

    task automatic test_ignored_reload();
        do_cmd(8'h4A, 1'b1);
        do_cmd(8'hC5, 1'b1);   // ignored opcode
        do_cmd(8'h85, 1'b1);   // ignored opcode
        do_id(8'h05, 1'b1);    // destination still 0x0A
        do_cmd(8'h47, 1'b1);   // reload destination
        do_id(8'h0A, 1'b1);
        do_id(8'h07, 1'b0);
        do_cmd(8'hC0, 1'b0);   // ignored while idle
    endtask

    task automatic test_simultaneous();
        do_cmd(8'h4A, 1'b1);
        cmd     = 8'h00;
        cmd_rdy = 1'b1;
        id      = 8'h0A;
        id_vld  = 1'b1;
        step();
        vectors++;
        if ({clr_cmd_rdy, clr_id_vld, in_transit} !== 3'b100) begin
            miscompares++;
            $display("FAIL simul_first got clr_cmd,clr_id,transit=%b expected 100",
                     {clr_cmd_rdy, clr_id_vld, in_transit});
        end
        cmd_rdy = 1'b0;
        step();
        vectors++;
        if ({clr_cmd_rdy, clr_id_vld, in_transit} !== 3'b010) begin
            miscompares++;
            $display("FAIL simul_second got clr_cmd,clr_id,transit=%b expected 010",
                     {clr_cmd_rdy, clr_id_vld, in_transit});
        end
        id_vld = 1'b0;
        step();
        vectors++;
        if ({clr_cmd_rdy, clr_id_vld, in_transit} !== 3'b000) begin
            miscompares++;
            $display("FAIL simul_done got clr_cmd,clr_id,transit=%b expected 000",
                     {clr_cmd_rdy, clr_id_vld, in_transit});
        end
    endtask

    // Both flags held high while idle: each clear alternates 1,0,1,0,...
    task automatic test_back_to_back();
        cmd     = 8'h80;
        cmd_rdy = 1'b1;
        id      = 8'h11;
        id_vld  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (clr_cmd_rdy !== ((k % 2) == 0) || clr_id_vld !== ((k % 2) == 0)) begin
                miscompares++;
                $display("FAIL held_req k=%0d clr_cmd_rdy=%b clr_ID_vld=%b expected %b",
                         k, clr_cmd_rdy, clr_id_vld, ((k % 2) == 0));
            end
        end
        cmd_rdy = 1'b0;
        id_vld  = 1'b0;
        step();
        vectors++;
        if (clr_cmd_rdy !== 1'b0 || clr_id_vld !== 1'b0 || in_transit !== 1'b0) begin
            miscompares++;
            $display("FAIL held_release clr_cmd_rdy=%b clr_ID_vld=%b in_transit=%b expected 0 0 0",
                     clr_cmd_rdy, clr_id_vld, in_transit);
        end
    endtask

    task automatic test_buzzer();
        logic exp_b;
        do_cmd(8'h4A, 1'b1);
        ok2move = 1'b0;
        #1;
        vectors++;
        if (go !== 1'b0 || buzz !== 1'b0) begin
            miscompares++;
            $display("FAIL buzz_block_start go=%b buzz=%b expected 0 0", go, buzz);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_b = ((k / 4) % 2) == 1;
            vectors++;
            if (buzz !== exp_b || buzz_n !== ~exp_b) begin
                miscompares++;
                $display("FAIL buzz_toggle k=%0d buzz=%b buzz_n=%b expected %b", k, buzz, buzz_n, exp_b);
            end
        end
        ok2move = 1'b1;
        #1;
        vectors++;
        if (go !== 1'b1) begin
            miscompares++;
            $display("FAIL buzz_go_restore go=%b expected 1", go);
        end
        step();
        vectors++;
        if (buzz !== 1'b0 || buzz_n !== 1'b1) begin
            miscompares++;
            $display("FAIL buzz_clear buzz=%b buzz_n=%b expected 0 1", buzz, buzz_n);
        end
        // Counter must restart from zero: first rise exactly 4 edges after re-blocking.
        ok2move = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (buzz !== (k == 4)) begin
                miscompares++;
                $display("FAIL buzz_restart k=%0d buzz=%b expected %b", k, buzz, (k == 4));
            end
        end
    endtask

    // Reset while moving and buzzing aborts; a held ID report is serviced after release.
    task automatic test_reset_mid();
        id     = 8'h2A;
        id_vld = 1'b1;
        rst_n  = 1'b0;
        step();
        vectors++;
        if ({in_transit, buzz, buzz_n, clr_id_vld, clr_cmd_rdy} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_mid got transit,buzz,buzz_n,clr_id,clr_cmd=%b expected 00100",
                     {in_transit, buzz, buzz_n, clr_id_vld, clr_cmd_rdy});
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (clr_id_vld !== 1'b1 || in_transit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_reservice clr_ID_vld=%b in_transit=%b expected 1 0",
                     clr_id_vld, in_transit);
        end
        id_vld  = 1'b0;
        ok2move = 1'b1;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cmd         = 8'h00;
        cmd_rdy     = 1'b0;
        id          = 8'h00;
        id_vld      = 1'b0;
        ok2move     = 1'b1;
        test_reset();
        test_go_match();
        test_stop();
        test_ignored_reload();
        test_simultaneous();
        test_back_to_back();
        test_buzzer();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmd_cntrl.md
# cmd_cntrl

Command controller sitting directly downstream of the barcode reader. Accepts 8-bit commands from the command receiver, latches a 6-bit destination station ID, and holds the vehicle in transit until the barcode reader reports a matching station ID. Acknowledges both producers with one-cycle clear pulses. Drives `go` to the motion stage and a piezo buzzer while motion is blocked.

## Interface
- `BUZZ_HALF`, 12500: clk cycles per buzzer half-period (2 kHz at 50 MHz); legal 2..32767.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low. One clock; reset is synchronous and active-low.
- `cmd`  in  8  command byte; [7:6] opcode, [5:0] destination ID.
- `cmd_rdy`  in  1  command valid, held until acknowledged.
- `clr_cmd_rdy`  out  1  one-cycle acknowledge of `cmd`.
- `ID`  in  8  station ID from barcode reader; [7:6] are always 00 when valid.
- `ID_vld`  in  1  station ID valid, held until acknowledged.
- `clr_ID_vld`  out  1  one-cycle acknowledge of `ID`.
- `OK2Move`  in  1  obstacle sensor; 1 = path clear.
- `in_transit`  out  1  vehicle has an active destination.
- `go`  out  1  motion enable = `in_transit & OK2Move` (combinational).
- `buzz`, `buzz_n`  out  1  buzzer drive, complementary.

## Operation
- Opcodes: 01 = GO (`dest_ID <= cmd[5:0]`), 00 = STOP, 10/11 = ignored (acknowledged, no other effect).
- Input qualification: `cmd_rdy` is considered only in cycles where `clr_cmd_rdy` is 0; `ID_vld` only where `clr_ID_vld` is 0. Prevents double-consumption of a held request.
- States: IDLE, MOVE. `in_transit` = 1 exactly in MOVE (registered).
- IDLE: qualified `cmd_rdy` -> `clr_cmd_rdy` pulse; GO: latch `dest_ID`, -> MOVE; else stay. Qualified `ID_vld` in IDLE -> `clr_ID_vld` pulse, ID discarded, stay.
- MOVE, qualified `cmd_rdy` (priority): acknowledge; STOP -> IDLE; GO -> reload `dest_ID`, stay; 10/11 -> stay. `ID_vld` not acknowledged this cycle; serviced next eligible cycle.
- MOVE, qualified `ID_vld` with no qualified `cmd_rdy`: acknowledge; `ID[5:0] == dest_ID` -> IDLE; mismatch -> stay.
- Buzzer: 15-bit counter runs while `in_transit & !OK2Move`; on reaching `BUZZ_HALF-1`, wraps to 0 and toggles `buzz`. When the condition is false the counter is held at 0 and `buzz` is 0. `buzz_n = ~buzz` at all times.
- `go` drops in the same cycle `OK2Move` falls; no debounce here.

## Timing
- Reset (`rst_n` low at a rising edge): state IDLE, `dest_ID` 0, `clr_cmd_rdy` 0, `clr_ID_vld` 0, `in_transit` 0, `go` 0, `buzz` 0, `buzz_n` 1, buzzer counter 0. Reset mid-transit aborts immediately; pending `cmd_rdy`/`ID_vld` are re-serviced after release.
- Qualified request sampled at edge N -> clear pulse high during cycle N+1, exactly 1 cycle. State and `in_transit` update at edge N. Producer drops its flag at edge N+1.
- Back-to-back: a new request presented in cycle N+2 is serviceable, giving a throughput of one request per 2 cycles per channel.
- First `buzz` rising edge `BUZZ_HALF` cycles after blocking begins; period 2*`BUZZ_HALF`.

## Test plan
- Reset: hold `rst_n`=0 two edges with `cmd_rdy`=1 -> all outputs at reset values, no clear pulse; after release, `clr_cmd_rdy` pulses once.
- GO then match: `cmd`=0x45 + `cmd_rdy` -> `clr_cmd_rdy` 1 cycle, `in_transit`=1, `go`=1 with `OK2Move`=1; `ID`=0x03 -> ack, stay; `ID`=0x05 -> ack, `in_transit`=0.
- STOP mid-transit: GO 0x4A, then `cmd`=0x00 -> `in_transit`=0 after ack; subsequent `ID`=0x0A acknowledged, no state change.
- Simultaneous: in MOVE, `cmd`=0x00 and `ID_vld` (matching) raised same cycle -> `clr_cmd_rdy` first, `clr_ID_vld` one cycle later, `in_transit`=0, single pulse each.
- Held request: keep `cmd_rdy`=1 for 3 cycles after ack -> exactly one `clr_cmd_rdy` per eligible cycle, never in consecutive cycles.
- Buzzer with `BUZZ_HALF`=4: in MOVE drop `OK2Move` -> `go`=0 same cycle, `buzz` toggles every 4 cycles, `buzz_n` complementary; raise `OK2Move` -> `buzz`=0, counter 0.
